// File: rtl/div_seq_restoring.sv
// Sequential unsigned restoring divider: one quotient bit per enabled clock,
// start/en handshake, registered quotient/remainder with a one-cycle done pulse.
module div_seq_restoring #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH:0]   a;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   a_sh;
   logic [WIDTH:0]   t;
   logic [WIDTH:0]   a_nx;
   logic [WIDTH-1:0] q_nx;

   // One shift-subtract step; a negative trial difference restores the shifted value
   always_comb begin
      a_sh = (a << 1) | (WIDTH + 1)'(q[WIDTH-1]);
      t    = a_sh - (WIDTH + 1)'(m);
      a_nx = a_sh;
      q_nx = {q[WIDTH-2:0], 1'b0};
      if (!t[WIDTH]) begin
         a_nx = t;
         q_nx = {q[WIDTH-2:0], 1'b1};
      end
   end

   // Control FSM and datapath registers; en=0 freezes everything including done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         a           <= '0;
         q           <= '0;
         m           <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else if (en) begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor != '0) begin
                     a     <= '0;
                     q     <= dividend;
                     m     <= divisor;
                     cnt   <= CW'(WIDTH);
                     busy  <= 1'b1;
                     state <= CALC;
                  end else begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state       <= FINISH;
                  end
               end
            end
            CALC: begin
               a   <= a_nx;
               q   <= q_nx;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  quotient    <= q_nx;
                  remainder   <= a_nx[WIDTH-1:0];
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= FINISH;
               end
            end
            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq_restoring.sv
// Self-checking bench for div_seq_restoring: latency/arithmetic model checked
// every cycle, plus directed tests with literal expectations and a random phase.
module tb_div_seq_restoring;

   localparam int unsigned WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] dividend = '0;
   logic [WIDTH-1:0] divisor = '0;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_by_zero;

   int total = 0;
   int passed = 0;

   div_seq_restoring #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start),
      .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder),
      .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
   endtask

   // Reference model: a pending job counts down WIDTH enabled edges, then done for one enabled edge
   int               m_left = 0;
   logic             m_done = 1'b0;
   logic [WIDTH-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
   logic             m_dz = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_dz = 1'b0;
      end else if (en) begin
         if (m_done) m_done = 1'b0;
         else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1; m_q = p_q; m_r = p_r; m_dz = 1'b0;
            end
         end else if (start) begin
            if (divisor == 0) begin
               m_done = 1'b1; m_q = '1; m_r = dividend; m_dz = 1'b1;
            end else begin
               p_q = dividend / divisor;
               p_r = dividend % divisor;
               m_left = WIDTH;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("cyc_quotient", int'(quotient), int'(m_q));
      chk("cyc_remainder", int'(remainder), int'(m_r));
      chk("cyc_dz", int'(div_by_zero), int'(m_dz));
      chk("cyc_busy", int'(busy), int'(m_left > 0));
      chk("cyc_done", int'(done), int'(m_done));
      chk("cyc_busy_done_excl", int'(busy & done), 0);
   end

   // One division from IDLE with literal expectations, latency and pulse width
   task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input int eq, input int er, input int edz);
      int n;
      @(posedge clk); #1;
      dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_accept", int'(busy), int'(b != 0));
      n = 0;
      while (!done && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("latency", n, (b == 0) ? 0 : WIDTH);
      chk("quotient", int'(quotient), eq);
      chk("remainder", int'(remainder), er);
      chk("div_by_zero", int'(div_by_zero), edz);
      chk("model_quotient", int'(m_q), eq);
      chk("model_remainder", int'(m_r), er);
      @(posedge clk); #1;
      chk("done_one_cycle", int'(done), 0);
   endtask

   initial begin
      int n;
      int ndone;
      // reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_quotient", int'(quotient), 0);
      chk("rst_remainder", int'(remainder), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_dz", int'(div_by_zero), 0);
      rst = 1'b0; en = 1'b1;

      // basic and boundary cases
      run(4'd13, 4'd3, 4, 1, 0);
      run(4'd15, 4'd1, 15, 0, 0);
      run(4'd6, 4'd7, 0, 6, 0);
      run(4'd0, 4'd5, 0, 0, 0);
      run(4'd15, 4'd15, 1, 0, 0);
      run(4'd9, 4'd0, 15, 9, 1);
      run(4'd8, 4'd2, 4, 0, 0);

      // start ignored while busy
      @(posedge clk); #1;
      dividend = 4'd10; divisor = 4'd3; start = 1'b1;
      @(posedge clk); #1;            // edge k
      start = 1'b0;
      @(posedge clk); #1;            // edge k+1
      dividend = 4'd15; divisor = 4'd1; start = 1'b1;
      @(posedge clk); #1;            // edge k+2 samples the ignored start
      start = 1'b0;
      n = 0;
      while (!done && n < 50) begin @(posedge clk); #1; n++; end
      chk("busy_start_quotient", int'(quotient), 3);
      chk("busy_start_remainder", int'(remainder), 1);
      ndone = 0;
      repeat (10) begin @(posedge clk); #1; if (done) ndone++; end
      chk("no_second_done", ndone, 0);

      // enable stall mid-CALC
      @(posedge clk); #1;
      dividend = 4'd14; divisor = 4'd4; start = 1'b1;
      @(posedge clk); #1;            // edge k
      start = 1'b0;
      n = 0;
      @(posedge clk); #1; n++;
      en = 1'b0;
      repeat (3) begin @(posedge clk); #1; n++; end
      en = 1'b1;
      while (!done && n < 50) begin @(posedge clk); #1; n++; end
      chk("stall_latency", n, WIDTH + 3);
      chk("stall_quotient", int'(quotient), 3);
      chk("stall_remainder", int'(remainder), 2);
      @(posedge clk); #1;

      // reset abort
      @(posedge clk); #1;
      dividend = 4'd12; divisor = 4'd5; start = 1'b1;
      @(posedge clk); #1;            // edge k
      start = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_quotient", int'(quotient), 0);
      chk("abort_remainder", int'(remainder), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      ndone = 0;
      repeat (6) begin @(posedge clk); #1; if (done) ndone++; end
      chk("abort_no_done", ndone, 0);
      run(4'd12, 4'd5, 2, 2, 0);

      // exhaustive sweep
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            run(WIDTH'(a), WIDTH'(b), (b == 0) ? 15 : a / b, (b == 0) ? a : a % b,
                int'(b == 0));

      // random phase: en/start/operands/reset, checked by the per-cycle compare
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         rst      = ($urandom_range(0, 299) == 0);
         en       = ($urandom_range(0, 7) != 0);
         start    = ($urandom_range(0, 2) == 0);
         dividend = WIDTH'($urandom);
         divisor  = ($urandom_range(0, 5) == 0) ? '0 : WIDTH'($urandom);
      end
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0; en = 1'b1;
      repeat (WIDTH + 4) @(posedge clk);
      #1;
      chk("final_idle_busy", int'(busy), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/div_seq_restoring.md
Name: div_seq_restoring

Overview:
- Sequential unsigned restoring divider. It uses a shift-subtract datapath, one quotient bit per clock.
- It is the inverse companion of the team's 4-bit shift-add multiplier, and it uses the same start/en control style.
- It accepts a dividend and divisor on a start pulse, iterates WIDTH cycles, then presents quotient and remainder with a one-cycle done pulse.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (range 2 to 16).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  clock enable; when 0, all registers hold.
- start  input  1  request to begin a division; sampled only in IDLE with en=1.
- dividend  input  WIDTH  unsigned dividend; captured on the accepting edge.
- divisor  input  WIDTH  unsigned divisor; captured on the accepting edge.
- quotient  output  WIDTH  registered result quotient.
- remainder  output  WIDTH  registered result remainder.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; result valid.
- div_by_zero  output  1  registered flag for the last result; set when divisor was 0.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; while it is asserted:
  - state=IDLE;
  - quotient, remainder, busy, done and div_by_zero are all 0;
  - internal A, Q, M and cnt are 0.
- Reset mid-operation aborts immediately, and no done is issued.
- States: IDLE, CALC, FINISH.
- Internal registers:
  - A: WIDTH+1 bits, partial remainder.
  - Q: WIDTH bits.
  - M: WIDTH bits.
  - cnt: ceil(log2(WIDTH+1)) bits.
- en=0: state, datapath and outputs all hold, including a pending done (the pulse stretches). start is ignored.
- IDLE, start=1, en=1 (accepting edge k):
  - divisor!=0: A<=0, Q<=dividend, M<=divisor, cnt<=WIDTH, busy<=1, state<=CALC.
  - divisor==0: quotient<=all ones, remainder<=dividend, div_by_zero<=1, done<=1, state<=FINISH. CALC is skipped.
- CALC, each enabled edge:
  - Shift {A,Q} left 1.
  - Compute T = shifted A minus zero-extended M, at WIDTH+1 bits.
  - If the MSB of T is 0: A<=T and the new Q LSB is 1. Otherwise A keeps the shifted value and the new Q LSB is 0.
  - cnt<=cnt-1.
- On the CALC edge where cnt==1 (the WIDTH-th iteration):
  - quotient<=final Q; remainder<=final A[WIDTH-1:0];
  - div_by_zero<=0, done<=1, busy<=0, state<=FINISH.
- FINISH, next enabled edge: done<=0, state<=IDLE. start is ignored in FINISH.
- Latency:
  - Normal case: done is high in the cycle after edge k+WIDTH.
  - Divide-by-zero: done is high in the cycle after edge k.
  - Minimum start-to-start spacing is WIDTH+2 enabled cycles.
- start while busy or in FINISH has no effect; operand changes after edge k have no effect.
- Outputs quotient, remainder and div_by_zero hold until the next completion or reset. They are not cleared at start.
- Invariant when divisor!=0: dividend = quotient*divisor + remainder, with remainder < divisor.
- Edge cases:
  - dividend=0 gives quotient=0, remainder=0.
  - dividend<divisor gives quotient=0, remainder=dividend.
  - divisor=1 gives quotient=dividend, remainder=0.
- busy and done are never high together.

Test Plan:
- Reset, then basic division: rst=1 for 2 cycles, then en=1, dividend=13, divisor=3, start pulse at edge k. Required: busy high from edge k through edge k+3, done high after edge k+4, quotient=4, remainder=1, div_by_zero=0.
- Boundary values:
  - 15/1 gives quotient=15, remainder=0.
  - 6/7 gives quotient=0, remainder=6.
  - 0/5 gives quotient=0, remainder=0.
  - 15/15 gives quotient=1, remainder=0.
  - Each completes with done exactly one cycle wide.
- Divide by zero: dividend=9, divisor=0, start. Required: done after the next edge, quotient=15, remainder=9, div_by_zero=1, busy never high. A following 8/2 gives quotient=4, remainder=0, div_by_zero=0.
- Start ignored while busy: start 10/3, then raise start with 15/1 at k+2. Required: result quotient=3, remainder=1; no second done until a new start is issued in IDLE.
- Enable stall and reset abort:
  - Start 14/4 and drop en for 3 cycles mid-CALC. Required: completion delayed by 3 cycles, quotient=3, remainder=2.
  - Separately, assert rst at k+2 of a 12/5 division. Required: all outputs 0 immediately, no done, and the block accepts the next start normally.
- Exhaustive sweep: all 256 operand pairs at WIDTH=4, checked against a reference model (quotient = a/b, remainder = a%b, divide-by-zero rule as above).
